// File: rtl/down_timer_pkg.sv
// Shared definitions for the loadable countdown timer.
// Holds the FSM state encoding used by down_counter_timer.
package down_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable countdown timer with a one-cycle done pulse.
// A loaded value counts down to zero after start. Optionally, the timer
// reloads itself and keeps cycling.
// Optional feature: define DOWN_TIMER_PAUSE_EN to add the pause port.
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - asynchronous active-high reset
//   load     - load request, samples load_val (highest priority)
//   load_val - value to count down from
//   start    - begin countdown from the current count
//   pause    - hold count while running (DOWN_TIMER_PAUSE_EN only)
//   count    - current count (registered)
//   busy     - high while running (registered)
//   done     - one-cycle pulse when the count reaches zero (registered)
module down_counter_timer
  import down_timer_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter bit          RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
`ifdef DOWN_TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hold;

`ifdef DOWN_TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // busy/done are computed for the next state so that they appear as registered outputs.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    if (load) begin
      // load aborts everything, including a start in the same cycle
      count_d  = load_val;
      reload_d = load_val;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (count_q != '0) begin
              state_d = ST_RUN;
              busy_d  = 1'b1;
            end else begin
              // zero-length run: straight to the done pulse
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (hold) begin
            busy_d = 1'b1;
          end else if (count_q <= WIDTH'(1)) begin
            // <= rather than == so the count can never wrap below zero
            count_d = '0;
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
            busy_d  = 1'b1;
          end
        end
        ST_DONE: begin
          // a zero reload value would create an endless train of done pulses, so go idle
          if (RELOAD && (reload_q != '0)) begin
            state_d = ST_RUN;
            count_d = reload_q;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
